// File: rtl/divider_pipe.sv
// Fully pipelined restoring divider with per-operation signed/unsigned mode, divide-by-zero
// flag, sideband tag and valid/ready flow control; BITS_PER_STAGE quotient bits per register.
module divider_pipe #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_STAGE = 2,
  parameter int TAG_WIDTH      = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic [WIDTH-1:0]     dividend_in,
  input  logic [WIDTH-1:0]     divisor_in,
  input  logic                 signed_in,
  input  logic [TAG_WIDTH-1:0] tag_in,
  input  logic                 data_valid_in,
  output logic                 ready_out,
  output logic [WIDTH-1:0]     quotient_out,
  output logic [WIDTH-1:0]     remainder_out,
  output logic [TAG_WIDTH-1:0] tag_out,
  output logic                 error_out,
  output logic                 data_valid_out,
  input  logic                 ready_in,
  output logic                 busy_out
);

  localparam int NSTAGE = (WIDTH + BITS_PER_STAGE - 1) / BITS_PER_STAGE;

  // aq starts as |dividend|; each iteration shifts its MSB into rem and its freed LSB
  // receives the new quotient bit, so after WIDTH iterations aq is |quotient|.
  typedef struct packed {
    logic                 valid;
    logic                 zero;
    logic                 qneg;
    logic                 rneg;
    logic [TAG_WIDTH-1:0] tag;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     aq;
    logic [WIDTH-1:0]     b;
  } stage_t;

  stage_t stg [NSTAGE+1];
  stage_t d0;
  stage_t last;
  logic   advance;
  logic   a_neg;
  logic   b_neg;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // A stalled output freezes the whole pipe, bubbles included.
  assign advance   = !(data_valid_out && !ready_in);
  assign ready_out = advance;

  assign a_neg = signed_in & dividend_in[WIDTH-1];
  assign b_neg = signed_in & divisor_in[WIDTH-1];

  // NOTE: every field of d0 gets a default first, so no path leaves it unassigned and
  // no latch is inferred.
  always_comb begin
    d0       = '0;
    d0.valid = data_valid_in;
    d0.zero  = (divisor_in == '0);
    d0.qneg  = a_neg ^ b_neg;
    d0.rneg  = a_neg;
    d0.tag   = tag_in;
    d0.aq    = a_neg ? -dividend_in : dividend_in;
    d0.b     = b_neg ? -divisor_in : divisor_in;
  end

  // NOTE: the whole stage struct is reset, not only the valid bit, so an operation
  // interrupted by reset can never leak partial data into a later result.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)    stg[0] <= '0;
    else if (advance) stg[0] <= d0;
  end

  for (genvar s = 1; s <= NSTAGE; s++) begin : g_stage
    localparam int DONE  = (s - 1) * BITS_PER_STAGE;
    localparam int ITERS = (WIDTH - DONE < BITS_PER_STAGE) ? (WIDTH - DONE) : BITS_PER_STAGE;

    stage_t d;

    // NOTE: blocking assignments here chain the ITERS iterations combinationally; each
    // iteration reads the value the previous one just produced.
    always_comb begin
      logic [WIDTH:0] trial;
      d     = stg[s-1];
      trial = '0;
      for (int i = 0; i < ITERS; i++) begin
        trial = {d.rem, d.aq[WIDTH-1]};
        d.aq  = {d.aq[WIDTH-2:0], 1'b0};
        if (trial >= {1'b0, d.b}) begin
          trial   = trial - {1'b0, d.b};
          d.aq[0] = 1'b1;
        end
        d.rem = trial[WIDTH-1:0];
      end
    end

    // NOTE: sequential state uses non-blocking assignments so all stages sample the
    // previous stage's value from before the edge.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)    stg[s] <= '0;
      else if (advance) stg[s] <= d;
    end
  end

  // With a zero divisor the restoring loop leaves |dividend| in rem, so the normal
  // remainder sign fix-up already returns the dividend as presented.
  assign last  = stg[NSTAGE];
  assign q_fix = last.zero ? '1 : (last.qneg ? -last.aq : last.aq);
  assign r_fix = last.rneg ? -last.rem : last.rem;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      data_valid_out <= 1'b0;
      quotient_out   <= '0;
      remainder_out  <= '0;
      tag_out        <= '0;
      error_out      <= 1'b0;
    end else if (advance) begin
      data_valid_out <= last.valid;
      if (last.valid) begin
        quotient_out  <= q_fix;
        remainder_out <= r_fix;
        tag_out       <= last.tag;
        error_out     <= last.zero;
      end
    end
  end

  always_comb begin
    busy_out = data_valid_out;
    for (int s = 0; s <= NSTAGE; s++) busy_out = busy_out | stg[s].valid;
  end

endmodule

// File: tb/tb_divider_pipe.sv
// Self-checking bench for divider_pipe: a 32-bit/2-bit-per-stage instance driven with directed
// and random traffic plus backpressure and reset, and 8-bit/BPS=3 and 16-bit/BPS=1 instances.
module tb_divider_pipe;

  localparam int NDUT = 3;
  localparam int DW  [NDUT] = '{32, 8, 16};
  localparam int LAT [NDUT] = '{18, 5, 18};

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic [7:0]  tag;
    logic        err;
    int          acc;
    int          stall0;
  } exp_t;

  logic        clk_in   = 1'b0;
  logic        rst_n_in = 1'b1;
  logic [31:0] dvd [NDUT];
  logic [31:0] dvs [NDUT];
  logic        sgn [NDUT];
  logic        vin [NDUT];
  logic        rdi [NDUT];
  logic [7:0]  tgi [NDUT];
  logic [31:0] quo [NDUT];
  logic [31:0] rmd [NDUT];
  logic [7:0]  tgo [NDUT];
  logic        rdo [NDUT];
  logic        vout [NDUT];
  logic        err [NDUT];
  logic        bsy [NDUT];
  logic [7:0]  q8, r8;
  logic [15:0] q16, r16;

  exp_t sb [NDUT][$];
  int   stalls [NDUT] = '{default: 0};
  int   cyc      = 0;
  int   last_acc = 0;
  int   n_cmp    = 0;
  int   n_fail   = 0;

  assign quo[1] = {24'd0, q8};
  assign rmd[1] = {24'd0, r8};
  assign quo[2] = {16'd0, q16};
  assign rmd[2] = {16'd0, r16};

  divider_pipe #(.WIDTH(32), .BITS_PER_STAGE(2), .TAG_WIDTH(8)) u_dut32 (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .dividend_in(dvd[0]), .divisor_in(dvs[0]), .signed_in(sgn[0]), .tag_in(tgi[0]),
    .data_valid_in(vin[0]), .ready_out(rdo[0]),
    .quotient_out(quo[0]), .remainder_out(rmd[0]), .tag_out(tgo[0]), .error_out(err[0]),
    .data_valid_out(vout[0]), .ready_in(rdi[0]), .busy_out(bsy[0]));

  divider_pipe #(.WIDTH(8), .BITS_PER_STAGE(3), .TAG_WIDTH(8)) u_dut8 (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .dividend_in(dvd[1][7:0]), .divisor_in(dvs[1][7:0]), .signed_in(sgn[1]), .tag_in(tgi[1]),
    .data_valid_in(vin[1]), .ready_out(rdo[1]),
    .quotient_out(q8), .remainder_out(r8), .tag_out(tgo[1]), .error_out(err[1]),
    .data_valid_out(vout[1]), .ready_in(rdi[1]), .busy_out(bsy[1]));

  divider_pipe #(.WIDTH(16), .BITS_PER_STAGE(1), .TAG_WIDTH(8)) u_dut16 (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .dividend_in(dvd[2][15:0]), .divisor_in(dvs[2][15:0]), .signed_in(sgn[2]), .tag_in(tgi[2]),
    .data_valid_in(vin[2]), .ready_out(rdo[2]),
    .quotient_out(q16), .remainder_out(r16), .tag_out(tgo[2]), .error_out(err[2]),
    .data_valid_out(vout[2]), .ready_in(rdi[2]), .busy_out(bsy[2]));

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  // Reference model: 64-bit signed arithmetic, truncating division, remainder takes the
  // dividend's sign; results masked to the operand width.
  function automatic void ref_div(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic s, output logic [31:0] q, output logic [31:0] r,
                                  output logic e);
    longint m, as, bs;
    m  = (longint'(1) << w) - 1;
    as = longint'(a) & m;
    bs = longint'(b) & m;
    if (s && a[w-1]) as = as - (longint'(1) << w);
    if (s && b[w-1]) bs = bs - (longint'(1) << w);
    if (bs == 0) begin
      q = 32'(m);
      r = 32'(longint'(a) & m);
      e = 1'b1;
    end else begin
      q = 32'((as / bs) & m);
      r = 32'((as % bs) & m);
      e = 1'b0;
    end
  endfunction

  // Scoreboard: push on every accepted input, pop and compare on every transferred output.
  // Latency is NSTAGE+2 cycles plus one per stall cycle seen since acceptance.
  always @(negedge clk_in) begin
    exp_t e;
    if (rst_n_in) begin
      for (int k = 0; k < NDUT; k++) begin
        if (vout[k] && rdi[k]) begin
          if (sb[k].size() == 0) begin
            check($sformatf("d%0d_spurious_valid", k), 64'(vout[k]), 64'd0);
          end else begin
            e = sb[k].pop_front();
            check($sformatf("d%0d_quot", k), 64'(quo[k]), 64'(e.q));
            check($sformatf("d%0d_rem", k), 64'(rmd[k]), 64'(e.r));
            check($sformatf("d%0d_tag", k), 64'(tgo[k]), 64'(e.tag));
            check($sformatf("d%0d_err", k), 64'(err[k]), 64'(e.err));
            check($sformatf("d%0d_latency", k), 64'(cyc - e.acc),
                  64'(LAT[k] + stalls[k] - e.stall0));
          end
        end
        if (vin[k] && rdo[k]) begin
          ref_div(DW[k], dvd[k], dvs[k], sgn[k], e.q, e.r, e.err);
          e.tag    = tgi[k];
          e.acc    = cyc;
          e.stall0 = stalls[k];
          sb[k].push_back(e);
        end
        if (vout[k] && !rdi[k]) stalls[k]++;
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the op.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic [7:0] t);
    int i;
    dvd[0] = a; dvs[0] = b; sgn[0] = s; tgi[0] = t; vin[0] = 1'b1;
    i = 0;
    @(negedge clk_in);
    while (!rdo[0] && i < 100) begin
      @(negedge clk_in);
      i++;
    end
    check("send_accept", 64'(rdo[0]), 64'd1);
    last_acc = cyc;
    @(posedge clk_in);
    #1;
    vin[0] = 1'b0;
  endtask

  function automatic bit idle();
    bit r = 1'b1;
    for (int k = 0; k < NDUT; k++) if (sb[k].size() != 0 || bsy[k]) r = 1'b0;
    return r;
  endfunction

  task automatic drain(input string name);
    for (int i = 0; i < 300 && !idle(); i++) @(negedge clk_in);
    check(name, 64'(idle()), 64'd1);
    @(posedge clk_in);
    #1;
  endtask

  task automatic expect_single(input string name, input logic [31:0] q, input logic [31:0] r,
                               input logic [7:0] t, input logic e);
    for (int i = 0; i < 40 && !vout[0]; i++) @(negedge clk_in);
    check({name, "_latency"}, 64'(cyc - last_acc), 64'(LAT[0]));
    check({name, "_quot"}, 64'(quo[0]), 64'(q));
    check({name, "_rem"}, 64'(rmd[0]), 64'(r));
    check({name, "_tag"}, 64'(tgo[0]), 64'(t));
    check({name, "_err"}, 64'(err[0]), 64'(e));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_valid"}, 64'(vout[0]), 64'd0);
    check({name, "_busy"}, 64'(bsy[0]), 64'd0);
    check({name, "_quot"}, 64'(quo[0]), 64'd0);
    check({name, "_rem"}, 64'(rmd[0]), 64'd0);
    check({name, "_tag"}, 64'(tgo[0]), 64'd0);
    check({name, "_err"}, 64'(err[0]), 64'd0);
    check({name, "_ready"}, 64'(rdo[0]), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the summary line");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      dvd[k] = '0; dvs[k] = '0; sgn[k] = 1'b0; tgi[k] = '0; vin[k] = 1'b0; rdi[k] = 1'b1;
    end

    // Reset state
    #1 rst_n_in = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(posedge clk_in);
    #1 rst_n_in = 1'b1;

    // Single unsigned op: 1000/7 -> 142 r 6, 18 cycles
    send(32'd1000, 32'd7, 1'b0, 8'h5A);
    check("busy_in_flight", 64'(bsy[0]), 64'd1);
    expect_single("t1", 32'd142, 32'd6, 8'h5A, 1'b0);
    drain("drain_single");

    // Signed cases, overflow, divide by zero and recovery, back to back
    send(32'hFFFF_FFF9, 32'd2, 1'b1, 8'h01);
    send(32'd7, 32'hFFFF_FFFE, 1'b1, 8'h02);
    send(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 8'h03);
    send(32'd123, 32'd0, 1'b0, 8'h04);
    send(32'd10, 32'd3, 1'b0, 8'h05);
    send(32'hFFFF_FF85, 32'd0, 1'b1, 8'h06);
    drain("drain_directed");

    // 40 back-to-back random ops must emerge as 40 consecutive valid results
    fork
      for (int i = 0; i < 40; i++)
        send($urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom,
             1'($urandom_range(0, 1)), 8'(i));
      begin
        int n;
        n = 0;
        for (int i = 0; i < 100 && !vout[0]; i++) @(negedge clk_in);
        for (int i = 0; i < 40; i++) begin
          if (vout[0]) n++;
          @(negedge clk_in);
        end
        check("stream_consecutive", 64'(n), 64'd40);
      end
    join
    drain("drain_stream");

    // Backpressure: hold ready_in low 5 cycles while a result is valid
    fork
      for (int i = 0; i < 8; i++)
        send($urandom, 32'($urandom_range(1, 1000)), 1'($urandom_range(0, 1)), 8'(8'h80 + i));
      begin
        for (int i = 0; i < 100 && !vout[0]; i++) @(negedge clk_in);
        @(posedge clk_in);
        #1 rdi[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk_in);
          check("bp_ready_low", 64'(rdo[0]), 64'd0);
          check("bp_valid_held", 64'(vout[0]), 64'd1);
          check("bp_quot_held", 64'(quo[0]), 64'(sb[0][0].q));
          check("bp_tag_held", 64'(tgo[0]), 64'(sb[0][0].tag));
        end
        @(posedge clk_in);
        #1 rdi[0] = 1'b1;
      end
    join
    drain("drain_backpressure");

    // Reset with 10 ops in flight: outputs clear at once, nothing stale afterwards
    for (int i = 0; i < 10; i++)
      send($urandom, 32'($urandom_range(1, 50)), 1'b0, 8'(8'hC0 + i));
    rst_n_in = 1'b0;
    #1 check_reset_outputs("rst_mid");
    for (int k = 0; k < NDUT; k++) sb[k].delete();
    @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    begin
      int stale;
      stale = 0;
      for (int i = 0; i < 25; i++) begin
        @(negedge clk_in);
        if (vout[0] || bsy[0]) stale++;
      end
      check("rst_no_stale", 64'(stale), 64'd0);
    end
    @(posedge clk_in);
    #1;
    send(32'd1000, 32'd7, 1'b0, 8'hA5);
    expect_single("post_rst", 32'd142, 32'd6, 8'hA5, 1'b0);
    drain("drain_post_reset");

    // 8-bit / BPS=3 and 16-bit / BPS=1 instances: corners then random stream
    for (int i = 0; i < 300; i++) begin
      for (int k = 1; k < NDUT; k++) begin
        logic [31:0] m, a, b;
        logic        s;
        m = 32'hFFFF_FFFF >> (32 - DW[k]);
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
        s = 1'($urandom_range(0, 1));
        case (i)
          0: begin a = ~(m >> 1); b = m; s = 1'b1; end
          1: b = 32'd0;
          2: begin a = 32'hFFFF_FFF9; b = 32'd2; s = 1'b1; end
          3: begin a = 32'd7; b = 32'hFFFF_FFFE; s = 1'b1; end
          default: ;
        endcase
        dvd[k] = a & m; dvs[k] = b & m; sgn[k] = s; tgi[k] = 8'(i); vin[k] = 1'b1;
      end
      @(posedge clk_in);
      #1;
    end
    vin[1] = 1'b0;
    vin[2] = 1'b0;
    drain("drain_sweep");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/divider_pipe.md
Name: divider_pipe

Overview:
- Parametrised, fully pipelined restoring divider; successor to the fixed 32-bit divider.
- Generic in operand width and in radix-2 iterations per register stage.
- Adds a per-transaction signed/unsigned mode, a divide-by-zero error flag, a sideband tag and valid/ready backpressure.
- Sits between pixel/coordinate math producers (e.g. homography projection) and downstream consumers that may stall.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- BITS_PER_STAGE, 2, quotient bits resolved per pipeline register (1..WIDTH); NSTAGE = ceil(WIDTH/BITS_PER_STAGE).
- TAG_WIDTH, 8, width of sideband tag carried alongside each operation.

Ports:
- clk_in  input  1  system clock, all logic rising-edge.
- rst_n_in  input  1  asynchronous active-low reset.
- dividend_in  input  WIDTH  dividend.
- divisor_in  input  WIDTH  divisor.
- signed_in  input  1  1 = two's-complement operands, 0 = unsigned.
- tag_in  input  TAG_WIDTH  opaque tag, returned with the result.
- data_valid_in  input  1  operands valid.
- ready_out  output  1  block accepts operands this cycle.
- quotient_out  output  WIDTH  quotient.
- remainder_out  output  WIDTH  remainder.
- tag_out  output  TAG_WIDTH  tag of the current result.
- error_out  output  1  divisor was zero for the current result.
- data_valid_out  output  1  result valid.
- ready_in  input  1  consumer accepts result this cycle.
- busy_out  output  1  any stage holds a valid operation.

Behaviour:
- Handshakes:
  - Input is accepted when data_valid_in && ready_out.
  - Output is transferred when data_valid_out && ready_in.
- Stall rule:
  - stall = data_valid_out && !ready_in.
  - ready_out = !stall, combinational.
  - During stall every pipeline register, including valid bits, holds its value.
  - Otherwise the entire pipe advances one stage per cycle; bubbles are not compressed.
- Structure:
  - Stage 0 (input register): captures mode, tag and zero-divisor flag. When signed_in, it takes absolute values and records qneg = sign(dividend) xor sign(divisor) and rneg = sign(dividend).
  - Stages 1..NSTAGE: each performs BITS_PER_STAGE restoring iterations combinationally (shift-in MSB, compare, subtract, set quotient bit), then registers.
  - The final stage when WIDTH is not a multiple of BITS_PER_STAGE performs only the remaining iterations.
  - Output stage: applies sign fix-up and registers the outputs.
- Latency: exactly NSTAGE+2 cycles from the accept edge to data_valid_out high, absent stalls. Throughput is one result per cycle.
- Arithmetic:
  - Unsigned: q = floor(a/b), r = a - q*b, with r < b.
  - Signed: truncation toward zero; quotient negated if qneg, remainder negated if rneg. |r| < |b| and r carries the sign of the dividend.
  - Signed overflow (a = -2^(WIDTH-1), b = -1): q = -2^(WIDTH-1), r = 0, error_out = 0.
  - Divide by zero (either mode): q = all ones, r = dividend as presented, error_out = 1.
- All sideband signals (tag, mode, error, signs) travel in lockstep with their operands.
- Reset: asynchronous on rst_n_in low.
  - All stage valid bits, data_valid_out, error_out and busy_out go to 0.
  - quotient_out, remainder_out and tag_out go to 0.
  - ready_out reads 1 after reset.
  - In-flight operations are discarded; no partial result ever appears after reset release.
- busy_out = OR of all stage valid bits, including the output stage.
- When data_valid_out is 0, outputs hold their last values and consumers ignore them.

Test Plan:
- Unsigned, WIDTH=32, BPS=2 (NSTAGE=16): 1000/7, tag 0x5A, accepted cycle 0 -> data_valid_out high on cycle 18; q=142, r=6, tag_out=0x5A, error_out=0.
- Signed: -7/2 -> q=-3 (0xFFFFFFFD), r=-1. Then 7/-2 -> q=-3, r=1. Then 0x80000000/-1 -> q=0x80000000, r=0, error_out=0.
- Divide by zero: 123/0 unsigned -> q=0xFFFFFFFF, r=123, error_out=1. The next operation, 10/3, has error_out=0, q=3, r=1.
- Back-to-back stream of 40 random ops with ready_in=1 -> 40 consecutive valid results, in order, matching a reference model; tags preserved.
- Backpressure: hold ready_in low for 5 cycles while the output is valid -> ready_out low for those cycles, the result is held stable, and no op is lost or duplicated. Pipeline resumes in order on release.
- Reset mid-flight: assert rst_n_in for 1 cycle with 10 ops in flight -> outputs and busy_out are 0 immediately (asynchronously). After release, no stale valid appears and a new op completes at NSTAGE+2.
- Parameter sweep: WIDTH=8 with BPS=3 (NSTAGE=3, latency 5) and WIDTH=16 with BPS=1 (latency 18) -> exhaustive or random check against the model.
